// File: rtl/uart_stream_mux_if.sv
// Byte-stream bundle between the UART receivers, the ingress mux and the parser.
// The mux connects through the slave modport; the environment uses master.
interface uart_stream_mux_if #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]            inReady;
  logic [CHANNELS*DATA_WIDTH-1:0] inData;
  logic [CHANNELS-1:0]            chEnable;
  logic                           outValid;
  logic [DATA_WIDTH-1:0]          outData;
  logic [CW-1:0]                  outChannel;
  logic                           outReady;
  logic [CHANNELS-1:0]            pending;
  logic [CHANNELS-1:0]            overflow;
  logic                           clearOverflow;

  modport master (
    output inReady, inData, chEnable, outReady, clearOverflow,
    input  outValid, outData, outChannel, pending, overflow
  );

  modport slave (
    input  inReady, inData, chEnable, outReady, clearOverflow,
    output outValid, outData, outChannel, pending, overflow
  );
endinterface

// File: rtl/uart_stream_mux.sv
// Multi-channel UART ingress mux: one FIFO per receiver, round-robin or fixed
// priority arbitration onto a single tagged ready/valid byte stream.
module uart_stream_mux #(
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ARB_MODE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_stream_mux_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [CW:0] NCH      = (CW+1)'(CHANNELS);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [PW-1:0]         ptr_t;
  typedef logic [PW:0]           cnt_t;
  typedef logic [CW-1:0]         chan_t;

  // Per-channel FIFO state
  data_t mem_q    [CHANNELS][DEPTH];
  ptr_t  wr_ptr_q [CHANNELS];
  ptr_t  wr_ptr_d [CHANNELS];
  ptr_t  rd_ptr_q [CHANNELS];
  ptr_t  rd_ptr_d [CHANNELS];
  cnt_t  cnt_q    [CHANNELS];
  cnt_t  cnt_d    [CHANNELS];

  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] drop;
  logic [CHANNELS-1:0] pop_vec;
  logic [CHANNELS-1:0] cand;
  logic [CHANNELS-1:0] pending_vec;
  logic [CHANNELS-1:0] overflow_q;
  logic [CHANNELS-1:0] overflow_d;

  // Arbiter and output register
  chan_t       rr_ptr_q;
  chan_t       rr_ptr_d;
  chan_t       grant_idx;
  logic [CW:0] rr_sum;
  logic        grant_valid;
  logic        out_free;
  logic        pop;

  logic  out_valid_q;
  logic  out_valid_d;
  data_t out_data_q;
  data_t out_data_d;
  chan_t out_chan_q;
  chan_t out_chan_d;

  // NOTE: every signal driven from always_comb gets a default before any
  // conditional assignment, so no path can leave it holding a value (latch).
  always_comb begin
    out_free    = !out_valid_q || bus.outReady;
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand[i] = (cnt_q[i] != '0) && bus.chEnable[i];
    end
    if (ARB_MODE == 1) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          grant_valid = 1'b1;
          grant_idx   = chan_t'(i);
        end
      end
    end else begin
      // Scan downward so the channel closest after the pointer wins last.
      for (int k = CHANNELS; k >= 1; k--) begin
        rr_sum = {1'b0, rr_ptr_q} + (CW+1)'(k);
        if (rr_sum >= NCH) rr_sum = rr_sum - NCH;
        if (cand[rr_sum[CW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_sum[CW-1:0];
        end
      end
    end
    pop = out_free && grant_valid;
  end

  // FIFO bookkeeping; a full FIFO drops the strobe even if popped this cycle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pop_vec[i]     = pop && (grant_idx == chan_t'(i));
      push[i]        = bus.inReady[i] && (cnt_q[i] != FULL_CNT);
      drop[i]        = bus.inReady[i] && (cnt_q[i] == FULL_CNT);
      pending_vec[i] = (cnt_q[i] != '0);
      wr_ptr_d[i]    = push[i]    ? wr_ptr_q[i] + ptr_t'(1) : wr_ptr_q[i];
      rd_ptr_d[i]    = pop_vec[i] ? rd_ptr_q[i] + ptr_t'(1) : rd_ptr_q[i];
      cnt_d[i]       = cnt_q[i];
      if (push[i] && !pop_vec[i]) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end else if (!push[i] && pop_vec[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
    end
    overflow_d = drop | (overflow_q & ~{CHANNELS{bus.clearOverflow}});
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[grant_idx][rd_ptr_q[grant_idx]];
      out_chan_d  = grant_idx;
      if (ARB_MODE == 0) rr_ptr_d = grant_idx;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: the byte storage is deliberately not reset; the reset counts and
  // pointers already mark it empty, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= bus.inData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every process
  // sees the pre-edge value regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      overflow_q  <= '0;
      rr_ptr_q    <= chan_t'(CHANNELS - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      overflow_q  <= overflow_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign bus.outValid   = out_valid_q;
  assign bus.outData    = out_data_q;
  assign bus.outChannel = out_chan_q;
  assign bus.pending    = pending_vec;
  assign bus.overflow   = overflow_q;

endmodule
